mem_axi_bridge: RTL and testbench
=================================

Name: mem_axi_bridge

Overview:
- Downstream neighbour of the MMU: takes the MMU's single-word physical request (request_enable pulse plus mode/addr/wdata/wstrb) and runs it as one AXI4-Lite master transaction toward the memory/peripheral interconnect.
- Returns one response_enable pulse with read data.
- Handles at most one transaction at a time; independent AW/W completion; error and overrun reporting.

Parameters:
- ADDR_WIDTH, 32, AXI/request address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- request_enable  in  1  one-cycle request pulse from MMU
- req_mode  in  1  0 = MEMREQ_READ, 1 = MEMREQ_WRITE
- req_addr  in  ADDR_WIDTH  physical address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  byte strobes
- response_enable  out  1  one-cycle completion pulse
- resp_data  out  DATA_WIDTH  read data; 0 for writes
- resp_error  out  1  valid with response_enable: RRESP/BRESP != OKAY
- busy  out  1  transaction in flight (state != IDLE)
- overrun  out  1  sticky: request_enable seen while busy; cleared only by rst
- m_axi_awaddr out ADDR_WIDTH; m_axi_awprot out 3 (constant 0); m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata out DATA_WIDTH; m_axi_wstrb out DATA_WIDTH/8; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
- m_axi_araddr out ADDR_WIDTH; m_axi_arprot out 3 (constant 0); m_axi_arvalid out 1; m_axi_arready in 1
- m_axi_rdata in DATA_WIDTH; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1

Behaviour:
- Reset (rst=1 at posedge): state IDLE. All valid/ready outputs, response_enable, resp_error, overrun are 0. resp_data, address, data and strobe registers are 0.
- Reset mid-transaction abandons it immediately; no response pulse is produced. The slave side relies on the interconnect being reset together.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
- IDLE with request_enable=1: latch addr/wdata/wstrb.
  - Read: go to RD_ADDR with arvalid=1.
  - Write: go to WR_ADDR_DATA with awvalid=1 and wvalid=1.
- RD_ADDR: hold araddr/arvalid stable until arready. On handshake: arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid&rready:
  - rready=0; resp_data=rdata; resp_error=(rresp!=0); response_enable=1 for the next cycle only; go to IDLE.
- WR_ADDR_DATA: AW and W are tracked independently.
  - awvalid drops the cycle after its own handshake; wvalid likewise.
  - Both handshakes may occur in the same cycle or in either order.
  - When both are done: bready=1, go to WR_RESP.
  - Asserting bready early is not allowed.
- WR_RESP: on bvalid&bready: bready=0; resp_data=0; resp_error=(bresp!=0); response_enable pulse; go to IDLE.
- Write with wstrb=0 is still issued on the bus unchanged.
- Valid signals never drop before their handshake. Payloads stay constant while valid.
- Latency with an always-ready slave (request in cycle 0):
  - Read: arvalid cycle 1, rready cycle 2, response_enable cycle 3.
  - Write: aw/wvalid cycle 1, bready cycle 2, response_enable cycle 3.
- response_enable is exactly one cycle wide. The state is already IDLE during the pulse cycle, so a new request_enable in that cycle is accepted (back-to-back).
- request_enable while busy (state != IDLE): request dropped, overrun set to 1, current transaction unaffected.
- resp_data and resp_error hold their values until the next completion.

Test Plan:
- Read 0x8000_0010, slave always ready, rdata 0xDEADBEEF, rresp 0 -> arvalid cycle 1, response_enable cycle 3 only, resp_data=0xDEADBEEF, resp_error=0.
- Write 0x8000_0020, wdata 0x12345678, wstrb 0b0011; wready asserted 3 cycles after awready -> awvalid drops after its handshake, wvalid held until its handshake, bready only after both; bresp=0 -> one response_enable, resp_data=0.
- Slave stalls arready 5 cycles and rvalid 4 cycles with rresp=2'b10 -> araddr/arvalid stable throughout; response pulse with resp_error=1.
- Second request_enable during busy read -> overrun=1 and stays 1; first read completes normally; only one response pulse.
- Back-to-back: new read issued in the response_enable cycle of a write -> accepted; arvalid the next cycle.
- rst=1 while in WR_RESP -> all outputs 0, state IDLE next cycle; no response pulse; a subsequent read completes normally.

Source files
------------

// File: rtl/mem_axi_bridge_if.sv
// AXI4-Lite master-side bus bundle for mem_axi_bridge.
// Every channel transfers when valid && ready are both high at a rising clock edge.
// Once raised, valid stays high with a constant payload until that edge, and ready may depend on valid.
interface mem_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/mem_axi_bridge.sv
// Turns one MMU physical request pulse into a single AXI4-Lite transaction and
// returns a one-cycle response pulse; one transaction in flight at a time.
module mem_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    request_enable,
    input  logic                    req_mode,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    response_enable,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_error,
    output logic                    busy,
    output logic                    overrun,
    output logic [2:0]              dbg_state_o,
    mem_axi_bridge_if.master        m_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR_DATA,
        S_WR_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_error_q, resp_error_d;
    logic                    resp_en_q, resp_en_d;
    logic                    overrun_q, overrun_d;
    logic                    aw_valid, w_valid;

    // AW and W each drop their valid on their own handshake.
    assign aw_valid = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
    assign w_valid  = (state_q == S_WR_ADDR_DATA) && !w_done_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        resp_en_d    = 1'b0;
        overrun_d    = overrun_q | (request_enable && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (request_enable) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_mode ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (m_axi.arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_axi.rvalid) begin
                    resp_data_d  = m_axi.rdata;
                    resp_error_d = (m_axi.rresp != 2'b00);
                    resp_en_d    = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WR_ADDR_DATA: begin
                if (aw_valid && m_axi.awready) begin
                    aw_done_d = 1'b1;
                end
                if (w_valid && m_axi.wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    resp_data_d  = '0;
                    resp_error_d = (m_axi.bresp != 2'b00);
                    resp_en_d    = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            resp_en_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            resp_en_q    <= resp_en_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = aw_valid;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = w_valid;
    assign m_axi.bready  = (state_q == S_WR_RESP);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state_q == S_RD_ADDR);
    assign m_axi.rready  = (state_q == S_RD_DATA);

    assign response_enable = resp_en_q;
    assign resp_data       = resp_data_q;
    assign resp_error      = resp_error_q;
    assign busy            = (state_q != S_IDLE);
    assign overrun         = overrun_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: a delay-configurable AXI4-Lite slave, a per-cycle
// protocol model derived from the transaction rules, and an expected-response queue.
module tb_mem_axi_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          request_enable;
    logic          req_mode;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          response_enable;
    logic [DW-1:0] resp_data;
    logic          resp_error;
    logic          busy;
    logic          overrun;
    logic [2:0]    dbg_state;

    mem_axi_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    mem_axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .request_enable  (request_enable),
        .req_mode        (req_mode),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wstrb       (req_wstrb),
        .response_enable (response_enable),
        .resp_data       (resp_data),
        .resp_error      (resp_error),
        .busy            (busy),
        .overrun         (overrun),
        .dbg_state_o     (dbg_state),
        .m_axi           (axi.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_d, r_d, aw_d, w_d, b_d;
        int          ovr_cyc;
        bit          rst_at_b;
        bit          chain;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          ovr_exp = 0;
    logic [DW-1:0] exp_q[$];
    logic        exp_err_q[$];
    vec_t        vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_slave();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_response_enable"}, response_enable, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_error"}, resp_error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_valids"}, {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
        check({tag, "_readies"}, {axi.rready, axi.bready}, 0);
        check({tag, "_addr"}, {axi.araddr, axi.awaddr}, 0);
        check({tag, "_wdata_wstrb"}, {axi.wdata, axi.wstrb}, 0);
    endtask

    function automatic vec_t mkv(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic [31:0] rdata, input logic [1:0] resp,
                                 input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
                                 input int ovr_cyc, input bit rst_at_b, input bit chain,
                                 input logic [31:0] exp_data, input logic exp_err, input int exp_cyc);
        vec_t v;
        v.mode = mode; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.rdata = rdata; v.resp = resp;
        v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
        v.ovr_cyc = ovr_cyc; v.rst_at_b = rst_at_b; v.chain = chain;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    // Called at #1 after a rising edge with the DUT idle; the request is driven in this cycle (cycle 0).
    task automatic run_txn(input vec_t t);
        int   c;
        bit   ar_done, r_done, aw_done, w_done, b_done, inj, fin;
        int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic [31:0] exp_d;
        logic exp_e;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0; inj = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        request_enable = 1'b1;
        req_mode  = t.mode;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_wstrb = t.wstrb;
        if (!t.rst_at_b) begin
            exp_q.push_back(t.exp_data);
            exp_err_q.push_back(t.exp_err);
        end
        @(posedge clk); #1;
        request_enable = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom_range(0, 15));
        c = 1;
        while (c <= 200) begin
            if (inj) ovr_exp = 1;
            inj = 0;
            request_enable = 1'b0;
            fin = t.mode ? b_done : r_done;
            check("response_enable", response_enable, fin);
            check("busy", busy, !fin);
            check("overrun", overrun, ovr_exp);
            check("prot", {axi.arprot, axi.awprot}, 0);
            if (t.mode) begin
                check("awvalid", axi.awvalid, !aw_done);
                check("wvalid", axi.wvalid, !w_done);
                check("bready", axi.bready, aw_done && w_done && !b_done);
                check("rd_idle", {axi.arvalid, axi.rready}, 0);
            end else begin
                check("arvalid", axi.arvalid, !ar_done);
                check("rready", axi.rready, ar_done && !r_done);
                check("wr_idle", {axi.awvalid, axi.wvalid, axi.bready}, 0);
            end
            if (axi.arvalid) check("araddr", axi.araddr, t.addr);
            if (axi.awvalid) check("awaddr", axi.awaddr, t.addr);
            if (axi.wvalid) check("wdata_wstrb", {axi.wdata, axi.wstrb}, {t.wdata, t.wstrb});
            if (fin) begin
                check("resp_cycle", c, t.exp_cyc);
                exp_d = exp_q.pop_front();
                exp_e = exp_err_q.pop_front();
                check("resp_data", resp_data, exp_d);
                check("resp_error", resp_error, exp_e);
                clear_slave();
                if (t.chain) return;
                @(posedge clk); #1;
                check("pulse_width", response_enable, 0);
                check("resp_hold", {resp_data, resp_error}, {exp_d, exp_e});
                check("idle_busy", busy, 0);
                return;
            end
            if (t.rst_at_b && axi.bready) begin
                clear_slave();
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                ovr_exp = 0;
                check_reset_state("mid_reset");
                @(posedge clk); #1;
                check("post_reset_no_pulse", {response_enable, busy}, 0);
                return;
            end
            if (c == t.ovr_cyc) begin
                request_enable = 1'b1;
                req_mode = $urandom_range(0, 1) != 0;
                inj = 1;
            end
            axi.arready = axi.arvalid && (ar_cnt >= t.ar_d);
            axi.rvalid  = ar_done && !r_done && (r_cnt >= t.r_d);
            axi.rdata   = axi.rvalid ? t.rdata : '0;
            axi.rresp   = axi.rvalid ? t.resp : 2'b00;
            axi.awready = axi.awvalid && (aw_cnt >= t.aw_d);
            axi.wready  = axi.wvalid && (w_cnt >= t.w_d);
            axi.bvalid  = aw_done && w_done && !b_done && (b_cnt >= t.b_d);
            axi.bresp   = axi.bvalid ? t.resp : 2'b00;
            if (axi.rvalid && axi.rready) r_done = 1;
            else if (ar_done && !r_done) r_cnt++;
            if (axi.bvalid && axi.bready) b_done = 1;
            else if (aw_done && w_done && !b_done) b_cnt++;
            if (axi.arvalid && axi.arready) ar_done = 1;
            else if (axi.arvalid) ar_cnt++;
            if (axi.awvalid && axi.awready) aw_done = 1;
            else if (axi.awvalid) aw_cnt++;
            if (axi.wvalid && axi.wready) w_done = 1;
            else if (axi.wvalid) w_cnt++;
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: no response after %0d cycles, required by cycle %0d", c, t.exp_cyc);
        clear_slave();
        request_enable = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ovr_exp = 0;
        exp_q.delete();
        exp_err_q.delete();
    endtask

    initial begin
        vec_t v;
        int   ar_d, r_d, aw_d, w_d, b_d, lat;
        rst = 1'b1;
        request_enable = 1'b0;
        req_mode = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        clear_slave();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        //          mode  addr          wdata         strb  rdata         rsp    ar r aw w b  ovr rst chn  exp_data      err cyc
        vecs[0] = mkv(1'b0, 32'h8000_0010, 32'h0,        4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 3);
        vecs[1] = mkv(1'b1, 32'h8000_0020, 32'h1234_5678, 4'h3, 32'h0,        2'b00, 0, 0, 0, 3, 0, 0, 0, 0, 32'h0,         0, 6);
        vecs[2] = mkv(1'b0, 32'h8000_0030, 32'h0,        4'h0, 32'hCAFE_F00D, 2'b10, 5, 4, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 1, 12);
        vecs[3] = mkv(1'b0, 32'h8000_0040, 32'h0,        4'h0, 32'h1111_2222, 2'b00, 2, 1, 0, 0, 0, 2, 0, 0, 32'h1111_2222, 0, 6);
        vecs[4] = mkv(1'b1, 32'h8000_0050, 32'hAABB_CCDD, 4'hF, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,         0, 3);
        vecs[5] = mkv(1'b0, 32'h8000_0060, 32'h0,        4'h0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 3);
        vecs[6] = mkv(1'b1, 32'h8000_0064, 32'h5555_AAAA, 4'h0, 32'h0,        2'b11, 0, 0, 2, 0, 2, 0, 0, 0, 32'h0,         1, 7);
        vecs[7] = mkv(1'b1, 32'h8000_0070, 32'h7777_7777, 4'hC, 32'h0,        2'b00, 0, 0, 0, 0, 3, 0, 1, 0, 32'h0,         0, 0);
        vecs[8] = mkv(1'b0, 32'h8000_0080, 32'h0,        4'h0, 32'h5A5A_5A5A, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_5A5A, 1, 3);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
        end

        for (int i = 0; i < 40; i++) begin
            ar_d = $urandom_range(0, 3);
            r_d  = $urandom_range(0, 3);
            aw_d = $urandom_range(0, 3);
            w_d  = $urandom_range(0, 3);
            b_d  = $urandom_range(0, 3);
            v = mkv($urandom_range(0, 1) != 0, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    ar_d, r_d, aw_d, w_d, b_d, 0, 0, (i != 39) && ($urandom_range(0, 2) == 0),
                    32'h0, 1'b0, 0);
            v.exp_data = v.mode ? 32'h0 : v.rdata;
            v.exp_err  = (v.resp != 2'b00);
            lat = v.mode ? (3 + ((aw_d > w_d) ? aw_d : w_d) + b_d) : (3 + ar_d + r_d);
            v.exp_cyc = lat;
            if ($urandom_range(0, 4) == 0) v.ovr_cyc = $urandom_range(1, lat - 1);
            run_txn(v);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
